ia_delay_line: RTL

Programmable transport delay for the spindle Ia firing-rate word, modelling afferent conduction delay between the spindle stage and the SPI master that ships f_rawfr_Ia to board 1. It sits directly downstream of the spindle and upstream of the SPI sender. It captures one 32-bit IEEE-754 sample per sim_clk and replays it D samples later through a circular buffer. Payload bits are never interpreted; the block is pure storage and sequencing.

---
 rtl/ia_delay_pkg.sv | 8 +
 rtl/ia_delay_line_ram.sv | 21 ++
 rtl/ia_delay_line.sv | 68 ++++++
 3 files changed

// File: rtl/ia_delay_pkg.sv
// ia_delay_pkg: shared defaults and the delay-index type for the Ia conduction-delay line.
package ia_delay_pkg;
   localparam int DEF_AW = 8;
   localparam int DEF_W = 32;
   localparam logic [DEF_AW-1:0] DEF_DELAY = 8'd20;
   localparam logic [DEF_W-1:0] DEF_FILL = 32'h0000_0000;
   typedef logic [DEF_AW-1:0] delay_t;
endpackage

// File: rtl/ia_delay_line_ram.sv
// delay_ram: simple dual-port sample store, one write port and one registered read port, no reset.
module delay_ram #(
   parameter int AW = 8,
   parameter int W = 32
) (
   input  logic          sim_clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);
   logic [W-1:0] mem [2**AW];
   logic [W-1:0] rd_data_q, rd_data_d;
   always_comb rd_data_d = mem[rd_addr];
   always_ff @(posedge sim_clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data_q <= rd_data_d;
   end
   assign rd_data = rd_data_q;
endmodule

// File: rtl/ia_delay_line.sv
// ia_delay_line: replays the Ia firing-rate word a programmable number of samples later.
module ia_delay_line
   import ia_delay_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int W = DEF_W,
   parameter logic [AW-1:0] DEFAULT_DELAY = DEF_DELAY,
   parameter logic [W-1:0] FILL_VALUE = DEF_FILL
) (
   input  logic          sim_clk,
   input  logic          reset_global,
   input  logic          clear,
   input  logic [W-1:0]  din,
   input  logic [AW-1:0] delay_req,
   input  logic          delay_load,
   output logic [W-1:0]  dout,
   output logic          dout_valid,
   output logic [AW-1:0] delay_active,
   output logic [AW-1:0] fill
);
   localparam logic [AW-1:0] FULL = '1;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, fill_q, fill_d, delay_q, delay_d, rd_addr;
   logic [W-1:0] dout_q, dout_d, prev_q, prev_d, ram_rd;
   logic valid_q, valid_d;
   // The RAM read is issued one edge early from next-state pointers; for D = 1 that
   // address is still being written, so the previous input word is used instead.
   always_comb begin
      wr_ptr_d = clear ? '0 : wr_ptr_q + 1'b1;
      fill_d = clear ? '0 : (fill_q == FULL ? fill_q : fill_q + 1'b1);
      delay_d = delay_load ? delay_req : delay_q;
      rd_addr = wr_ptr_d - delay_d;
      prev_d = din;
      valid_d = !clear && (fill_d >= delay_q);
      dout_d = !valid_d ? FILL_VALUE
             : (delay_q == '0) ? din
             : (delay_q == AW'(1)) ? prev_q
             : ram_rd;
   end
   always_ff @(posedge sim_clk or posedge reset_global) begin
      if (reset_global) begin
         wr_ptr_q <= '0;
         fill_q <= '0;
         delay_q <= DEFAULT_DELAY;
         dout_q <= FILL_VALUE;
         valid_q <= 1'b0;
         prev_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q <= fill_d;
         delay_q <= delay_d;
         dout_q <= dout_d;
         valid_q <= valid_d;
         prev_q <= prev_d;
      end
   end
   delay_ram #(.AW(AW), .W(W)) u_ram (
      .sim_clk(sim_clk),
      .wr_en(!clear),
      .wr_addr(wr_ptr_q),
      .wr_data(din),
      .rd_addr(rd_addr),
      .rd_data(ram_rd)
   );
   assign dout = dout_q;
   assign dout_valid = valid_q;
   assign delay_active = delay_q;
   assign fill = fill_q;
endmodule
